// File: rtl/adder_arb_pkg.sv
// Shared types and sizing helpers for the adder arbiter and its round-robin picker.
package adder_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int W_A_DEF = 16;
  localparam int W_B_DEF = 8;

  // Latency countdown width; a zero-latency adder still needs a 1-bit counter.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first eligible requester after last_i, with wrap.
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IW-1:0]      last_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] pick_o
);

  logic [IW-1:0] idx;

  assign valid_o = |eligible_i;

  // Walk from the farthest candidate back to the nearest so the nearest match wins.
  always_comb begin
    pick_o = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_i) + k) % NUM_REQ);
      if (eligible_i[idx]) begin
        pick_o      = '0;
        pick_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one W_A + W_B -> W_A+1 adder between NUM_REQ requesters.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W_A     = W_A_DEF,
  parameter int W_B     = W_B_DEF,
  parameter int ADD_LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*W_A-1:0] op_a_i,
  input  logic [NUM_REQ*W_B-1:0] op_b_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [W_A:0]           result_o,
  output logic                   busy_o,
  output logic [W_A-1:0]         adder_in1_o,
  output logic [W_B-1:0]         adder_in2_o,
  input  logic [W_A:0]           adder_out_i
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(ADD_LAT);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      last_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [W_A:0]       result_q;
  logic               busy_q;
  logic [W_A-1:0]     in1_q;
  logic [W_B-1:0]     in2_q;

  logic [NUM_REQ-1:0] eligible_d;
  logic [NUM_REQ-1:0] pick_d;
  logic               pick_valid_d;
  logic [IW-1:0]      pick_idx_d;
  logic [W_A-1:0]     sel_a_d;
  logic [W_B-1:0]     sel_b_d;

  // A requester still seeing its done pulse must not be re-granted in that cycle.
  assign eligible_d = req_i & ~done_q;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_picker (
    .eligible_i(eligible_d),
    .last_i    (last_q),
    .valid_o   (pick_valid_d),
    .pick_o    (pick_d)
  );

  always_comb begin
    sel_a_d    = '0;
    sel_b_d    = '0;
    pick_idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_d[i]) begin
        sel_a_d    = op_a_i[i*W_A +: W_A];
        sel_b_d    = op_b_i[i*W_B +: W_B];
        pick_idx_d = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (pick_valid_d) begin
            gnt_q   <= pick_d;
            in1_q   <= sel_a_d;
            in2_q   <= sel_b_d;
            last_q  <= pick_idx_d;
            cnt_q   <= CW'(ADD_LAT);
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            result_q <= adder_out_i;
            done_q   <= gnt_q;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;
  assign adder_in1_o = in1_q;
  assign adder_in2_o = in2_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic against a timestamp-based model.
module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int WA  = 16;
  localparam int WB  = 8;
  localparam int LAT = 1;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [WA-1:0]   a_arr [N];
  logic [WB-1:0]   b_arr [N];
  logic [N*WA-1:0] op_a;
  logic [N*WB-1:0] op_b;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [WA:0]     result;
  logic            busy;
  logic [WA-1:0]   in1;
  logic [WB-1:0]   in2;
  logic [WA:0]     add_out = '0;

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_flat
    assign op_a[gi*WA +: WA] = a_arr[gi];
    assign op_b[gi*WB +: WB] = b_arr[gi];
  end

  adder_arbiter #(
    .NUM_REQ(N),
    .W_A    (WA),
    .W_B    (WB),
    .ADD_LAT(LAT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .gnt_o      (gnt),
    .done_o     (done),
    .result_o   (result),
    .busy_o     (busy),
    .adder_in1_o(in1),
    .adder_in2_o(in2),
    .adder_out_i(add_out)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared adder: one register stage.
  always @(posedge clk) add_out <= {1'b0, in1} + (WA+1)'(in2);

  // Reference model: owner, grant timestamp and latched operands.
  bit            m_busy;
  logic [IW-1:0] m_owner;
  logic [IW-1:0] m_last;
  int            m_start;
  int            cyc = 0;
  logic [N-1:0]  m_done;
  logic [WA:0]   m_result;
  logic [WA-1:0] m_in1;
  logic [WB-1:0] m_in2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = '0;
    m_last   = IW'(N - 1);
    m_done   = '0;
    m_result = '0;
    m_in1    = '0;
    m_in2    = '0;
  endtask

  task automatic model_step();
    logic [N-1:0]  elig;
    logic [IW-1:0] j;
    bit            found;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      if (cyc == m_start + LAT + 1) begin
        m_result = (WA+1)'(int'(m_in1) + int'(m_in2));
        m_done   = N'(1) << m_owner;
        m_busy   = 1'b0;
        $display("txn req=%0d a=%h b=%h sum=%h", m_owner, m_in1, m_in2, m_result);
      end
    end else begin
      elig   = req & ~m_done;
      m_done = '0;
      found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = IW'((int'(m_last) + k) % N);
        if (!found && elig[j]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = j;
          m_last  = j;
          m_start = cyc;
          m_in1   = a_arr[j];
          m_in2   = b_arr[j];
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("gnt", gnt, m_busy ? (N'(1) << m_owner) : '0);
    chk("done", done, m_done);
    chk("busy", busy, m_busy);
    chk("result", result, m_result);
    chk("in1", in1, m_in1);
    chk("in2", in2, m_in2);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (done == '0 && n < 20);
    if (done == '0) chk("wait_done", 64'(|done), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [IW-1:0] ii;
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    model_reset();
    @(negedge clk);
    compare_all();
    cycle();
    rst_n = 1'b1;

    // Carry out of the top bit.
    a_arr[0] = 16'hFFFF;
    b_arr[0] = 8'h01;
    req      = 4'b0001;
    cycle();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_in1", in1, 16'hFFFF);
    chk("t1_in2", in2, 8'h01);
    wait_done(n);
    chk("t1_lat", n, 2);
    chk("t1_done", done, 4'b0001);
    chk("t1_res", result, 17'h10000);
    req = '0;
    cycle();
    chk("t1_busy", busy, 0);
    chk("t1_done_clr", done, 0);

    // All four requesting after reset: served 0..3, captures 3 cycles apart.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 16'(16'h1000 * i);
      b_arr[i] = 8'(i);
    end
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_done(n);
      chk("t2_spacing", n, 3);
      chk("t2_done", done, N'(1) << k);
      chk("t2_res", result, 17'(17'h1001 * k));
      req = req & ~done;
    end

    // Single held requester: no re-grant during its done cycle.
    a_arr[2] = 16'h1234;
    b_arr[2] = 8'h56;
    req      = 4'b0100;
    wait_done(n);
    chk("t3_res", result, 17'h0128A);
    a_arr[2] = 16'h00AA;
    b_arr[2] = 8'h11;
    cycle();
    chk("t3_no_regrant", gnt, 4'b0000);
    cycle();
    chk("t3_regrant", gnt, 4'b0100);
    wait_done(n);
    chk("t3_res2", result, 17'h000BB);

    // Rotation from last=2 and wrap from last=3.
    req = 4'b1010;
    cycle();
    chk("t4_first", gnt, 4'b1000);
    wait_done(n);
    req = 4'b0010;
    cycle();
    chk("t4_second", gnt, 4'b0010);
    wait_done(n);
    req = 4'b1000;
    wait_done(n);
    req = '0;
    cycle();
    req = 4'b1001;
    cycle();
    chk("t4_wrap", gnt, 4'b0001);
    wait_done(n);
    req = '0;
    cycle();

    // Operand change during WAIT is ignored.
    a_arr[0] = 16'h0005;
    b_arr[0] = 8'h20;
    req      = 4'b0001;
    cycle();
    a_arr[0] = 16'h00FF;
    cycle();
    chk("t5_hold", in1, 16'h0005);
    wait_done(n);
    chk("t5_res", result, 17'h00025);
    req = '0;
    cycle();

    // Asynchronous reset in the middle of an operation.
    req = 4'b1111;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_gnt", gnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_res", result, 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("t6_first", gnt, 4'b0001);
    for (int c = 0; c < 12; c++) cycle();
    req = '0;
    for (int c = 0; c < 4; c++) cycle();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        ii = IW'(i);
        if (req[ii]) begin
          if (m_done[ii]) begin
            if ($urandom_range(0, 1) == 0) begin
              req[ii] = 1'b0;
            end else begin
              a_arr[ii] = 16'($urandom);
              b_arr[ii] = 8'($urandom);
            end
          end else if ($urandom_range(0, 63) == 0) begin
            req[ii] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[ii]   = 1'b1;
          a_arr[ii] = ($urandom_range(0, 3) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                                  : 16'($urandom);
          b_arr[ii] = 8'($urandom);
        end
        if ($urandom_range(0, 7) == 0) a_arr[ii] = 16'($urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one bigadder (16-bit + 8-bit → 17-bit) between NUM_REQ requesters.
- Round-robin selection of one requester per operation.
- Latches the granted requester's operands onto the adder inputs and waits out the adder latency.
- Captures the 17-bit sum and returns it with a one-cycle done pulse to the owner; sits between requesting datapath blocks and the single adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- W_A, 16, width of operand A (adder in1).
- W_B, 8, width of operand B (adder in2); result width is W_A+1.
- ADD_LAT, 1, adder clock edges from input change to registered out valid (0 = combinational).

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NUM_REQ  per-requester request; held high until own done pulse.
- op_a  in  NUM_REQ*W_A  flattened A operands, requester i at [i*W_A +: W_A].
- op_b  in  NUM_REQ*W_B  flattened B operands, requester i at [i*W_B +: W_B].
- gnt  out  NUM_REQ  one-hot grant, high for the whole operation.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- result  out  W_A+1  sum of last completed op; held until next completion.
- busy  out  1  high while an operation is in flight.
- adder_in1  out  W_A  to bigadder in1.
- adder_in2  out  W_B  to bigadder in2.
- adder_out  in  W_A+1  from bigadder out.

Behaviour:
- Reset values (async, reset=0): gnt=0, done=0, result=0, busy=0, adder_in1=0, adder_in2=0, state=IDLE, cnt=0, last=NUM_REQ-1.
- FSM has two states.
- IDLE:
  - eligible = req & ~done; a requester whose done is high this cycle is masked.
  - If eligible≠0: pick first set bit searching from (last+1) mod NUM_REQ upward with wrap.
  - At that edge (E0): gnt=onehot(i), adder_in1=op_a[i], adder_in2=op_b[i], last=i, cnt=ADD_LAT, busy=1, → WAIT.
  - done clears to 0 on any IDLE edge.
- WAIT:
  - adder_in1/2 and gnt held constant; requester operand changes are ignored.
  - If cnt≠0: cnt−1.
  - If cnt==0: result=adder_out, done=gnt, gnt=0, busy=0, → IDLE.
- Timing:
  - The capture edge is E0+ADD_LAT+1; done is high for exactly the following cycle.
  - Minimum spacing between grants is ADD_LAT+2 cycles (one IDLE cycle, coinciding with done).
- Arithmetic: no truncation. Result is the full W_A+1-bit adder_out. The carry is bit W_A, e.g. 0xFFFF+0x01=0x10000.
- req dropped mid-operation: the operation still completes, and done still pulses to that requester. There is no abort.
- Simultaneous requests: exactly one grant; the others wait. Fairness guarantees at most NUM_REQ−1 operations before any held request is served.
- Reset mid-operation: all outputs clear immediately and no done pulse is produced. The in-flight result is discarded and arbitration restarts at requester 0.
- adder_in1/2 retain the last operands in IDLE (no toggling when idle).

Decomposition:
- Shared package (adder_arb_pkg):
  - state encodings IDLE/WAIT;
  - default widths W_A=16, W_B=8;
  - helper constant for the count width clog2(ADD_LAT+1).
- One natural sub-module: rr_picker.
  - Combinational round-robin priority encoder.
  - Inputs: eligible[NUM_REQ] and last. Outputs: valid and one-hot pick.
- The FSM, counter and operand/result registers stay in adder_arbiter.

Test Plan:
- After reset release, req=0001, op_a[0]=0xFFFF, op_b[0]=0x01 (ADD_LAT=1) → gnt=0001 after next edge, adder_in1=0xFFFF, adder_in2=0x01, done=0001 for one cycle 2 edges after grant, result=0x10000, busy low again.
- req=1111 held, op_a[i]=0x1000*i, op_b[i]=i → grants in order 0,1,2,3 with no overlap. Results in order: 0x0000, 0x1001, 0x2002, 0x3003, each with its own done pulse. Consecutive grants are 3 cycles apart.
- Only req[2] held continuously → no re-grant in its done cycle; next grant on the edge after done falls. Second result correct.
- With last=2, req=1010 → grant 3 first, then 1; with last=3, req=1001 → grant 0 first.
- Change op_a[0] from 0x0005 to 0x00FF while in WAIT → adder_in1 stays 0x0005 and result=0x0005+op_b[0].
- Assert reset low during WAIT → gnt, busy, done, result drop to 0 without waiting for a clock edge. No done after release. With req=1111, the first grant is requester 0.
